// File: rtl/y86_fetch_decode.sv
// SEQ Y86-64 fetch + decode stage: splits the instruction window into fields, computes valP,
// reads the 15-entry register file and writes back valE/valM on the clock edge.
module y86_fetch_decode #(
    parameter int unsigned IMEM_SIZE = 256
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [63:0]        PC,
    input  logic [0:79]        instr,
    input  logic               cnd,
    input  logic [63:0]        valE,
    input  logic [63:0]        valM,
    output logic [3:0]         icode,
    output logic [3:0]         ifun,
    output logic [3:0]         rA,
    output logic [3:0]         rB,
    output logic signed [63:0] valC,
    output logic [63:0]        valP,
    output logic               instr_valid,
    output logic               imem_error,
    output logic               halt_flag,
    output logic signed [63:0] valA,
    output logic signed [63:0] valB,
    output logic signed [63:0] reg_0,
    output logic signed [63:0] reg_1,
    output logic signed [63:0] reg_2,
    output logic signed [63:0] reg_3,
    output logic signed [63:0] reg_4,
    output logic signed [63:0] reg_5,
    output logic signed [63:0] reg_6,
    output logic signed [63:0] reg_7,
    output logic signed [63:0] reg_8,
    output logic signed [63:0] reg_9,
    output logic signed [63:0] reg_10,
    output logic signed [63:0] reg_11,
    output logic signed [63:0] reg_12,
    output logic signed [63:0] reg_13,
    output logic signed [63:0] reg_14
);

    logic [7:0]  b [10];
    logic [3:0]  len;
    logic        has_regs;
    logic [3:0]  src_a, src_b, dst_e, dst_m;
    logic        wr_en;
    logic [63:0] regs_q [15];

    always_comb begin
        for (int k = 0; k < 10; k++) b[k] = instr[8*k +: 8];
    end

    assign icode       = b[0][7:4];
    assign ifun        = b[0][3:0];
    assign instr_valid = (icode <= 4'hB);
    assign halt_flag   = (icode == 4'h0);
    assign imem_error  = (PC >= 64'(IMEM_SIZE));
    assign wr_en       = instr_valid && !imem_error;

    always_comb begin
        has_regs = 1'b0;
        len      = 4'd1;
        valC     = '0;
        src_a    = 4'hF;
        src_b    = 4'hF;
        dst_e    = 4'hF;
        dst_m    = 4'hF;
        case (icode)
            4'h2: begin has_regs = 1'b1; len = 4'd2; src_a = rA;
                        dst_e = cnd ? rB : 4'hF; end
            4'h3: begin has_regs = 1'b1; len = 4'd10; dst_e = rB;
                        valC = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}; end
            4'h4: begin has_regs = 1'b1; len = 4'd10; src_a = rA; src_b = rB;
                        valC = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}; end
            4'h5: begin has_regs = 1'b1; len = 4'd10; src_b = rB; dst_m = rA;
                        valC = {b[9], b[8], b[7], b[6], b[5], b[4], b[3], b[2]}; end
            4'h6: begin has_regs = 1'b1; len = 4'd2; src_a = rA; src_b = rB; dst_e = rB; end
            4'h7: begin len = 4'd9;
                        valC = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]}; end
            4'h8: begin len = 4'd9; src_b = 4'h4; dst_e = 4'h4;
                        valC = {b[8], b[7], b[6], b[5], b[4], b[3], b[2], b[1]}; end
            4'h9: begin src_a = 4'h4; src_b = 4'h4; dst_e = 4'h4; end
            4'hA: begin has_regs = 1'b1; len = 4'd2; src_a = rA; src_b = 4'h4; dst_e = 4'h4; end
            4'hB: begin has_regs = 1'b1; len = 4'd2; src_a = 4'h4; src_b = 4'h4;
                        dst_e = 4'h4; dst_m = rA; end
            default: ;
        endcase
    end

    assign rA   = has_regs ? b[1][7:4] : 4'hF;
    assign rB   = has_regs ? b[1][3:0] : 4'hF;
    assign valP = PC + {60'd0, len};

    // Register 4'hF does not exist; reading it yields zero.
    assign valA = (src_a == 4'hF) ? 64'sd0 : regs_q[src_a];
    assign valB = (src_b == 4'hF) ? 64'sd0 : regs_q[src_b];

    // valM is written last so it wins when dstE == dstM (popq %rsp).
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 15; i++) regs_q[i] <= '0;
        end else if (wr_en) begin
            if (dst_e != 4'hF) regs_q[dst_e] <= valE;
            if (dst_m != 4'hF) regs_q[dst_m] <= valM;
        end
    end

    assign reg_0  = regs_q[0];
    assign reg_1  = regs_q[1];
    assign reg_2  = regs_q[2];
    assign reg_3  = regs_q[3];
    assign reg_4  = regs_q[4];
    assign reg_5  = regs_q[5];
    assign reg_6  = regs_q[6];
    assign reg_7  = regs_q[7];
    assign reg_8  = regs_q[8];
    assign reg_9  = regs_q[9];
    assign reg_10 = regs_q[10];
    assign reg_11 = regs_q[11];
    assign reg_12 = regs_q[12];
    assign reg_13 = regs_q[13];
    assign reg_14 = regs_q[14];

endmodule

// File: tb/tb_y86_fetch_decode.sv
// Bench for y86_fetch_decode: table of decode vectors through a scoreboard queue,
// then hand-written write-back sequences against a tracked register image.
module tb_y86_fetch_decode;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [63:0]        PC;
    logic [0:79]        instr;
    logic               cnd;
    logic [63:0]        valE, valM;
    logic [3:0]         icode, ifun, rA, rB;
    logic signed [63:0] valC, valA, valB;
    logic [63:0]        valP;
    logic               instr_valid, imem_error, halt_flag;
    logic signed [63:0] rv [15];

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_reg [15];

    always #5 clk = ~clk;

    y86_fetch_decode #(.IMEM_SIZE(256)) dut (
        .clk(clk), .rst_n(rst_n), .PC(PC), .instr(instr), .cnd(cnd),
        .valE(valE), .valM(valM),
        .icode(icode), .ifun(ifun), .rA(rA), .rB(rB), .valC(valC), .valP(valP),
        .instr_valid(instr_valid), .imem_error(imem_error), .halt_flag(halt_flag),
        .valA(valA), .valB(valB),
        .reg_0(rv[0]), .reg_1(rv[1]), .reg_2(rv[2]), .reg_3(rv[3]), .reg_4(rv[4]),
        .reg_5(rv[5]), .reg_6(rv[6]), .reg_7(rv[7]), .reg_8(rv[8]), .reg_9(rv[9]),
        .reg_10(rv[10]), .reg_11(rv[11]), .reg_12(rv[12]), .reg_13(rv[13]), .reg_14(rv[14])
    );

    typedef struct {
        logic [63:0] pc;
        logic [79:0] w;
        logic [3:0]  icode, ifun, ra, rb;
        logic [63:0] valc, valp;
        logic        valid, halt, imem;
    } vec_t;

    vec_t tbl [16];
    vec_t exp_q [$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, expv);
        end
    endtask

    task automatic drive(input logic [63:0] pc, input logic [79:0] w, input logic c,
                         input logic [63:0] e, input logic [63:0] m);
        @(negedge clk);
        PC = pc; instr = w; cnd = c; valE = e; valM = m;
        #1;
    endtask

    task automatic tick_and_check(input string tag);
        @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) chk($sformatf("%s reg_%0d", tag, i), rv[i], exp_reg[i]);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        rst_n = 1'b0; PC = 0; instr = '0; cnd = 1'b0; valE = 0; valM = 0;
        for (int i = 0; i < 15; i++) exp_reg[i] = 64'd0;

        //        pc        window                              ic    if    rA    rB    valC                   valP        vld halt imem
        tbl[0]  = '{64'h2,    {8'h10, 72'd0},                     4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h3,      1, 0, 0};
        tbl[1]  = '{64'h3,    {16'h2001, 64'd0},                  4'h2, 4'h0, 4'h0, 4'h1, 64'h0,                 64'h5,      1, 0, 0};
        tbl[2]  = '{64'h40,   80'h30F3_8877665544332211,          4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788,  64'h4A,     1, 0, 0};
        tbl[3]  = '{64'h7,    80'h80_0000001000000001_00,         4'h8, 4'h0, 4'hF, 4'hF, 64'h0100000010000000,  64'h10,     1, 0, 0};
        tbl[4]  = '{64'h10,   80'h73_EFBEADDE00000000_00,         4'h7, 4'h3, 4'hF, 4'hF, 64'hDEADBEEF,          64'h19,     1, 0, 0};
        tbl[5]  = '{64'h20,   {8'h90, 72'd0},                     4'h9, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h21,     1, 0, 0};
        tbl[6]  = '{64'h30,   {16'h6123, 64'd0},                  4'h6, 4'h1, 4'h2, 4'h3, 64'h0,                 64'h32,     1, 0, 0};
        tbl[7]  = '{64'h50,   {16'hA06F, 64'd0},                  4'hA, 4'h0, 4'h6, 4'hF, 64'h0,                 64'h52,     1, 0, 0};
        tbl[8]  = '{64'h60,   {16'hB04F, 64'd0},                  4'hB, 4'h0, 4'h4, 4'hF, 64'h0,                 64'h62,     1, 0, 0};
        tbl[9]  = '{64'h70,   {16'hC012, 64'd0},                  4'hC, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h71,     0, 0, 0};
        tbl[10] = '{64'h80,   80'd0,                              4'h0, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h81,     1, 1, 0};
        tbl[11] = '{64'h90,   80'h4012_0800000000000000,          4'h4, 4'h0, 4'h1, 4'h2, 64'h8,                 64'h9A,     1, 0, 0};
        tbl[12] = '{64'hFF,   80'h5034_1000000000000000,          4'h5, 4'h0, 4'h3, 4'h4, 64'h10,                64'h109,    1, 0, 0};
        tbl[13] = '{64'hF0,   {16'hFF12, 64'd0},                  4'hF, 4'hF, 4'hF, 4'hF, 64'h0,                 64'hF1,     0, 0, 0};
        tbl[14] = '{64'h100,  {8'h10, 72'd0},                     4'h1, 4'h0, 4'hF, 4'hF, 64'h0,                 64'h101,    1, 0, 1};
        tbl[15] = '{64'h1000, 80'h30F3_8877665544332211,          4'h3, 4'h0, 4'hF, 4'h3, 64'h1122334455667788,  64'h100A,   1, 0, 1};

        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 15; i++) chk($sformatf("reset reg_%0d", i), rv[i], 64'd0);

        // Decode table runs with reset held so the register file stays at zero.
        for (int n = 0; n < 16; n++) begin
            drive(tbl[n].pc, tbl[n].w, 1'b1, 64'h55, 64'h66);
            exp_q.push_back(tbl[n]);
            v = exp_q.pop_front();
            chk($sformatf("v%0d icode", n), {60'd0, icode}, {60'd0, v.icode});
            chk($sformatf("v%0d ifun", n),  {60'd0, ifun},  {60'd0, v.ifun});
            chk($sformatf("v%0d rA", n),    {60'd0, rA},    {60'd0, v.ra});
            chk($sformatf("v%0d rB", n),    {60'd0, rB},    {60'd0, v.rb});
            chk($sformatf("v%0d valC", n),  valC,           v.valc);
            chk($sformatf("v%0d valP", n),  valP,           v.valp);
            chk($sformatf("v%0d valid", n), {63'd0, instr_valid}, {63'd0, v.valid});
            chk($sformatf("v%0d halt", n),  {63'd0, halt_flag},   {63'd0, v.halt});
            chk($sformatf("v%0d imem", n),  {63'd0, imem_error},  {63'd0, v.imem});
            chk($sformatf("v%0d valA", n),  valA, 64'd0);
            chk($sformatf("v%0d valB", n),  valB, 64'd0);
        end
        tick_and_check("table_end");

        drive(64'h0, {8'h10, 72'd0}, 1'b0, 64'h0, 64'h0);
        rst_n = 1'b1;
        tick_and_check("nop");

        // irmovq $7, %rax
        drive(64'h0, 80'h30F0_0700000000000000, 1'b0, 64'd7, 64'd0);
        exp_reg[0] = 64'd7;
        tick_and_check("irmov_rax");

        // cmovXX %rax,%rcx not taken, then taken
        drive(64'h3, {16'h2001, 64'd0}, 1'b0, 64'd7, 64'd0);
        chk("cmov valA", valA, 64'd7);
        chk("cmov valP", valP, 64'd5);
        tick_and_check("cmov_nt");
        drive(64'h3, {16'h2001, 64'd0}, 1'b1, 64'd7, 64'd0);
        exp_reg[1] = 64'd7;
        tick_and_check("cmov_t");

        drive(64'h0, 80'h30F2_0400000000000000, 1'b0, 64'd4, 64'd0);
        exp_reg[2] = 64'd4;
        tick_and_check("irmov_rdx");
        drive(64'h0, 80'h30F3_0900000000000000, 1'b0, 64'd9, 64'd0);
        exp_reg[3] = 64'd9;
        tick_and_check("irmov_rbx");

        // addq %rdx,%rbx: pre-edge reads old value, post-edge reads new
        drive(64'h5, {16'h6023, 64'd0}, 1'b0, 64'd13, 64'd0);
        chk("opq valA", valA, 64'd4);
        chk("opq valB", valB, 64'd9);
        chk("opq valP", valP, 64'd7);
        exp_reg[3] = 64'd13;
        tick_and_check("opq");
        chk("opq valB post", valB, 64'd13);

        drive(64'h0, 80'h30F4_0001000000000000, 1'b0, 64'h100, 64'd0);
        exp_reg[4] = 64'h100;
        tick_and_check("irmov_rsp");

        drive(64'h7, 80'h80_0000001000000001_00, 1'b0, 64'hF8, 64'd0);
        chk("call valC", valC, 64'h0100000010000000);
        chk("call valP", valP, 64'd16);
        chk("call valB", valB, 64'h100);
        exp_reg[4] = 64'hF8;
        tick_and_check("call");

        // popq %rsp: valM must win over valE
        drive(64'h20, {16'hB04F, 64'd0}, 1'b0, 64'd100, 64'd55);
        chk("popq valA", valA, 64'hF8);
        chk("popq valB", valB, 64'hF8);
        exp_reg[4] = 64'd55;
        tick_and_check("popq_rsp");

        drive(64'h22, {16'hB00F, 64'd0}, 1'b0, 64'd200, 64'd77);
        exp_reg[4] = 64'd200;
        exp_reg[0] = 64'd77;
        tick_and_check("popq_rax");

        drive(64'h24, {16'hC034, 64'd0}, 1'b1, 64'd999, 64'd999);
        chk("inv valid", {63'd0, instr_valid}, 64'd0);
        chk("inv valP", valP, 64'h25);
        chk("inv valA", valA, 64'd0);
        chk("inv valB", valB, 64'd0);
        tick_and_check("invalid");

        drive(64'd256, 80'h30F0_AA00000000000000, 1'b0, 64'hAA, 64'd0);
        chk("imem err", {63'd0, imem_error}, 64'd1);
        chk("imem rB", {60'd0, rB}, 64'd0);
        chk("imem valP", valP, 64'd266);
        tick_and_check("imem_nowrite");

        drive(64'h30, 80'h5034_1000000000000000, 1'b0, 64'h210, 64'h33);
        chk("mrmov valB", valB, 64'd200);
        chk("mrmov valC", valC, 64'h10);
        exp_reg[3] = 64'h33;
        tick_and_check("mrmov");

        drive(64'h40, 80'd0, 1'b1, 64'h77, 64'h88);
        chk("halt flag", {63'd0, halt_flag}, 64'd1);
        chk("halt valP", valP, 64'h41);
        tick_and_check("halt");

        drive(64'h0, 80'h30F1_0500000000000000, 1'b0, 64'd5, 64'd0);
        rst_n = 1'b0;
        for (int i = 0; i < 15; i++) exp_reg[i] = 64'd0;
        tick_and_check("reset_wr");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
